tx_gate_ctrl: RTL and testbench

//  Upstream stage of the Tx-on output pad. It turns the raw, asynchronous, active-low SS pin

---
 rtl/tx_gate_pkg.sv | 19 +
 rtl/tx_gate_ctrl_ss_sync.sv | 26 ++
 rtl/tx_gate_ctrl.sv | 131 +++++++++++++
 tb/tb_tx_gate_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_gate_pkg.sv
// Shared types and default parameters for the Tx-on gate controller.
// Used by tx_gate_ctrl and its SS synchroniser.
package tx_gate_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    TX_ON   = 2'd2,
    HOLDOFF = 2'd3
  } tx_state_t;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int HOLDOFF_CYC_DEF  = 16;
  localparam int TX_MAX_CYC_DEF   = 1000000;
  localparam int CNT_W_DEF        = 24;
  localparam int BURST_W_DEF      = 16;

endpackage

// File: rtl/tx_gate_ctrl_ss_sync.sv
// Flop-chain synchroniser for the raw active-low SS pin; the only clock-domain crossing.
// Resets to all ones so a held-low pin cannot look asserted straight out of reset.
module ss_sync
  import tx_gate_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_raw,
  output logic ss_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], ss_raw};
    end
  end

  assign ss_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tx_gate_ctrl.sv
// Tx-on gate: synchronised, debounced, holdoff-protected transmit gate with burst counter.
// Optional on-time watchdog when TX_GATE_CTRL_TIMEOUT_EN is defined.
//
//   state   | meaning
//   IDLE    | gate off, waiting for synced SS low with enable high
//   QUAL    | debouncing SS assert
//   TX_ON   | gate on
//   HOLDOFF | gate forced off; leaves only after HOLDOFF_CYC cycles and SS seen released
module tx_gate_ctrl
  import tx_gate_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
  parameter int TX_MAX_CYC   = TX_MAX_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int BURST_W      = BURST_W_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_SS,
  input  logic               i_Enable,
  output logic               o_Tx_On,
  output logic               o_Busy,
  output logic               o_Timeout,
  output logic [BURST_W-1:0] o_Burst_Cnt
);

  // The IDLE cycle that first sees SS low is the first debounce sample, so QUAL needs one fewer.
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'((DEBOUNCE_CYC > 1) ? DEBOUNCE_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_MAX_CYC - 1);

  logic             ss_s;
  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             burst_done;
  logic             timeout_set;
  logic             timeout_clr;
  logic             timeout_q;

  ss_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ss_sync (
    .clk    (i_Clk),
    .rst    (i_Rst),
    .ss_raw (i_SS),
    .ss_s   (ss_s)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    burst_done  = 1'b0;
    timeout_set = 1'b0;
    timeout_clr = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s && i_Enable) begin
          timeout_clr = 1'b1;
          state_nxt   = (DEBOUNCE_CYC > 1) ? QUAL : TX_ON;
        end
      end
      QUAL: begin
        if (ss_s || !i_Enable) begin
          state_nxt = IDLE;
        end else if (cnt == QUAL_LAST) begin
          state_nxt = TX_ON;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_ON: begin
        // A release in the watchdog's final cycle is a normal exit, not a timeout.
        if (ss_s || !i_Enable) begin
          state_nxt  = HOLDOFF;
          burst_done = 1'b1;
`ifdef TX_GATE_CTRL_TIMEOUT_EN
        end else if (cnt == TX_LAST) begin
          state_nxt   = HOLDOFF;
          burst_done  = 1'b1;
          timeout_set = 1'b1;
`endif
        end else if (cnt != TX_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          if (ss_s) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_Tx_On     <= 1'b0;
      o_Busy      <= 1'b0;
      timeout_q   <= 1'b0;
      o_Burst_Cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Outputs decode the next state so they switch on the same edge as the state.
      o_Tx_On <= (state_nxt == TX_ON);
      o_Busy  <= (state_nxt != IDLE);
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr) begin
        timeout_q <= 1'b0;
      end
      if (burst_done) begin
        o_Burst_Cnt <= o_Burst_Cnt + BURST_W'(1);
      end
    end
  end

  assign o_Timeout = timeout_q;

endmodule

// File: tb/tb_tx_gate_ctrl.sv
// Self-checking bench for tx_gate_ctrl: scenario tasks with a cycle-level expectation model.
// Builds with or without TX_GATE_CTRL_TIMEOUT_EN.
module tb_tx_gate_ctrl;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 16;
  localparam int TXMAX = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss  = 1'b1;
  logic        en  = 1'b1;
  logic        tx_on, busy, tmo;
  logic [15:0] bcnt;
  logic        tx_on_w, busy_w, tmo_w;
  logic [3:0]  bcnt_w;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_cnt = '0;
  logic        m_to  = 1'b0;

  typedef struct {
    int          rise;
    int          len;
    int          busy_at;
    int          n_rise;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  tx_gate_ctrl #(
    .SYNC_STAGES (SYNC), .DEBOUNCE_CYC (DEB), .HOLDOFF_CYC (HOLD),
    .TX_MAX_CYC (TXMAX), .CNT_W (24), .BURST_W (16)
  ) dut (
    .i_Clk (clk), .i_Rst (rst), .i_SS (ss), .i_Enable (en),
    .o_Tx_On (tx_on), .o_Busy (busy), .o_Timeout (tmo), .o_Burst_Cnt (bcnt)
  );

  // Narrow burst counter instance sharing the stimulus, used to see the wrap.
  tx_gate_ctrl #(
    .SYNC_STAGES (SYNC), .DEBOUNCE_CYC (DEB), .HOLDOFF_CYC (HOLD),
    .TX_MAX_CYC (TXMAX), .CNT_W (24), .BURST_W (4)
  ) dut_w (
    .i_Clk (clk), .i_Rst (rst), .i_SS (ss), .i_Enable (en),
    .o_Tx_On (tx_on_w), .o_Busy (busy_w), .o_Timeout (tmo_w), .o_Burst_Cnt (bcnt_w)
  );

  // Edge k is the k-th rising edge after the stimulus starts; SS low for edges 1..low and re_lo+1..re_hi.
  function automatic exp_t predict(input int low, input int re_lo, input int re_hi, input int en_drop);
    exp_t e;
    int   k_last, rel, fall;
    bit   qual;
    k_last    = (re_hi > low) ? re_hi : low;
    qual      = (low >= 1) && (en_drop < 0 || en_drop >= SYNC + 1);
    e.n_rise  = (low >= DEB && (en_drop < 0 || en_drop >= SYNC + DEB)) ? 1 : 0;
    e.rise    = 0;
    e.len     = 0;
    e.to      = 1'b0;
    e.busy_at = k_last + SYNC + 1;
    if (e.n_rise == 1) begin
      e.rise = SYNC + DEB;
      rel    = low + SYNC + 1;
      if (en_drop > 0 && en_drop + 1 < rel) rel = en_drop + 1;
      fall = rel;
`ifdef TX_GATE_CTRL_TIMEOUT_EN
      if (e.rise + TXMAX < rel) begin
        fall = e.rise + TXMAX;
        e.to = 1'b1;
      end
`endif
      e.len = fall - e.rise;
      if (fall + HOLD > e.busy_at) e.busy_at = fall + HOLD;
      m_cnt = m_cnt + 16'd1;
    end
    if (qual) m_to = e.to;
    e.to  = m_to;
    e.cnt = m_cnt;
    return e;
  endfunction

  // Drives one SS pattern and records gate timing; returns once the FSM is idle again.
  task automatic run_seq(input int low, input int re_lo, input int re_hi, input int en_drop,
                         output int len, output int rise_at, output int busy_at,
                         output int n_rise, output bit done);
    int k_last, fall_at;
    bit prev;
    k_last  = (re_hi > low) ? re_hi : low;
    rise_at = 0;
    fall_at = 0;
    busy_at = 0;
    n_rise  = 0;
    done    = 1'b0;
    prev    = tx_on;
    ss      = (low > 0) ? 1'b0 : 1'b1;
    en      = (en_drop == 0) ? 1'b0 : 1'b1;
    for (int k = 1; k <= k_last + HOLD + 100; k++) begin
      @(negedge clk);
      if (tx_on && !prev) begin
        n_rise++;
        if (rise_at == 0) rise_at = k;
      end
      if (!tx_on && prev && fall_at == 0) fall_at = k;
      prev = tx_on;
      if (k == en_drop) en = 1'b0;
      ss = !((k < low) || (k >= re_lo && k < re_hi));
      if (k >= k_last + SYNC + 1 && !busy) begin
        busy_at = k;
        done    = 1'b1;
        break;
      end
    end
    len = (rise_at != 0 && fall_at != 0) ? fall_at - rise_at : 0;
    ss  = 1'b1;
    en  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1;
    ss  = 1'b0;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_on, busy, tmo, bcnt} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got tx=%b busy=%b to=%b cnt=%0d expected all 0", tx_on, busy, tmo, bcnt);
    end
    rst = 1'b0;
    k   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tx_on) begin
        k = i;
        break;
      end
    end
    n_cmp++;
    if (k !== SYNC + DEB) begin
      n_err++;
      $display("FAIL reset_rise_edge: got %0d expected %0d", k, SYNC + DEB);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tx_on, busy, bcnt} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_mid_burst: got tx=%b busy=%b cnt=%0d expected all 0", tx_on, busy, bcnt);
    end
    ss = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_cnt = '0;
    m_to  = 1'b0;
  endtask

  task automatic test_glitch();
    int   lows[3] = '{3, 1, 4};
    exp_t e;
    int   len, r, b, n;
    bit   d;
    foreach (lows[i]) begin
      sb_q.push_back(predict(lows[i], 0, 0, -1));
      run_seq(lows[i], 0, 0, -1, len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || n !== e.n_rise || len !== e.len) begin
        n_err++;
        $display("FAIL glitch_low%0d: got done=%b rises=%0d len=%0d expected rises=%0d len=%0d",
                 lows[i], d, n, len, e.n_rise, e.len);
      end
      n_cmp++;
      if (bcnt !== e.cnt || b !== e.busy_at) begin
        n_err++;
        $display("FAIL glitch_cnt_busy%0d: got cnt=%0d busy_at=%0d expected cnt=%0d busy_at=%0d",
                 lows[i], bcnt, b, e.cnt, e.busy_at);
      end
    end
  endtask

  task automatic test_burst();
    int   lows[2] = '{50, 12};
    exp_t e;
    int   len, r, b, n;
    bit   d;
    foreach (lows[i]) begin
      sb_q.push_back(predict(lows[i], 0, 0, -1));
      run_seq(lows[i], 0, 0, -1, len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || r !== e.rise || len !== e.len) begin
        n_err++;
        $display("FAIL burst_low%0d: got done=%b rise=%0d len=%0d expected rise=%0d len=%0d",
                 lows[i], d, r, len, e.rise, e.len);
      end
      n_cmp++;
      if (bcnt !== e.cnt || b !== e.busy_at) begin
        n_err++;
        $display("FAIL burst_cnt_busy%0d: got cnt=%0d busy_at=%0d expected cnt=%0d busy_at=%0d",
                 lows[i], bcnt, b, e.cnt, e.busy_at);
      end
    end
  endtask

  task automatic test_holdoff();
    int   re_hi[2] = '{60, 30};
    exp_t e;
    int   len, r, b, n;
    bit   d;
    foreach (re_hi[i]) begin
      sb_q.push_back(predict(20, 25, re_hi[i], -1));
      run_seq(20, 25, re_hi[i], -1, len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || n !== e.n_rise || b !== e.busy_at) begin
        n_err++;
        $display("FAIL holdoff_re%0d: got done=%b rises=%0d busy_at=%0d expected rises=%0d busy_at=%0d",
                 re_hi[i], d, n, b, e.n_rise, e.busy_at);
      end
      n_cmp++;
      if (bcnt !== e.cnt) begin
        n_err++;
        $display("FAIL holdoff_cnt%0d: got %0d expected %0d", re_hi[i], bcnt, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int   lows[3] = '{60, 23, 22};
    exp_t e;
    int   len, r, b, n;
    bit   d;
    foreach (lows[i]) begin
      sb_q.push_back(predict(lows[i], 0, 0, -1));
      run_seq(lows[i], 0, 0, -1, len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || len !== e.len || n !== e.n_rise || b !== e.busy_at) begin
        n_err++;
        $display("FAIL ontime_low%0d: got done=%b len=%0d rises=%0d busy_at=%0d expected len=%0d rises=%0d busy_at=%0d",
                 lows[i], d, len, n, b, e.len, e.n_rise, e.busy_at);
      end
      n_cmp++;
      if (tmo !== e.to || bcnt !== e.cnt) begin
        n_err++;
        $display("FAIL ontime_flag%0d: got to=%b cnt=%0d expected to=%b cnt=%0d",
                 lows[i], tmo, bcnt, e.to, e.cnt);
      end
    end
  endtask

  task automatic test_enable();
    int   drops[2] = '{15, 0};
    exp_t e;
    int   len, r, b, n;
    bit   d;
    foreach (drops[i]) begin
      sb_q.push_back(predict(40, 0, 0, drops[i]));
      run_seq(40, 0, 0, drops[i], len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || len !== e.len || n !== e.n_rise || b !== e.busy_at) begin
        n_err++;
        $display("FAIL enable_drop%0d: got done=%b len=%0d rises=%0d busy_at=%0d expected len=%0d rises=%0d busy_at=%0d",
                 drops[i], d, len, n, b, e.len, e.n_rise, e.busy_at);
      end
      n_cmp++;
      if (bcnt !== e.cnt || tmo !== e.to) begin
        n_err++;
        $display("FAIL enable_cnt%0d: got cnt=%0d to=%b expected cnt=%0d to=%b", drops[i], bcnt, tmo, e.cnt, e.to);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   low, len, r, b, n;
    bit   d;
    for (int i = 0; i < 16; i++) begin
      low = 5 + (i % 4) * 3;
      sb_q.push_back(predict(low, 0, 0, -1));
      run_seq(low, 0, 0, -1, len, r, b, n, d);
      e = sb_q.pop_front();
      n_cmp++;
      if (!d || len !== e.len || bcnt !== e.cnt) begin
        n_err++;
        $display("FAIL b2b_%0d: got done=%b len=%0d cnt=%0d expected len=%0d cnt=%0d",
                 i, d, len, bcnt, e.len, e.cnt);
      end
    end
    n_cmp++;
    if (bcnt_w !== m_cnt[3:0]) begin
      n_err++;
      $display("FAIL burst_wrap: got %0d expected %0d", bcnt_w, m_cnt[3:0]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_burst();
    test_holdoff();
    test_timeout();
    test_enable();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got hang expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
